// File: rtl/frame_sequencer.sv
// Frame sequencer: paces pixels into a 3x3 line-buffer loader and re-times its windows
// with centre coordinates and frame markers. Define FRAME_SEQ_STATS_EN to build the stall counter.
module frame_sequencer #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  s_pixel,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        ld_rstN,
    output logic [7:0]  ld_pixel,
    output logic        ld_pixel_valid,
    input  logic [71:0] ld_window,
    input  logic        ld_window_valid,
    output logic [71:0] m_window,
    output logic        m_valid,
    output logic [15:0] m_row,
    output logic [15:0] m_col,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_eof,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [31:0] stall_cycles
);

    localparam logic [15:0] LAST_COL     = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] IN_ROWS      = 16'(IMAGE_HEIGHT);
    localparam logic [15:0] IN_LAST_ROW  = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] OUT_ROWS     = 16'(IMAGE_HEIGHT - 2);
    localparam logic [15:0] LAST_OUT_ROW = 16'(IMAGE_HEIGHT - 3);

    typedef enum logic [2:0] {IDLE, FLUSH, ACTIVE, DRAIN, DONE} state_t;

    state_t      r_state;
    logic [15:0] r_colIn;
    logic [15:0] r_inRows;
    logic [15:0] r_colOut;
    logic [15:0] r_outRows;
    logic        r_ldRstN;
    logic [71:0] r_mWindow;
    logic        r_mValid;
    logic [15:0] r_mRow;
    logic [15:0] r_mCol;
    logic        r_mSof;
    logic        r_mEol;
    logic        r_mEof;
    logic        r_busy;
    logic        r_frameDone;
    logic        r_err;

    logic [15:0] w_rowGap;
    logic        w_sReady;
    logic        w_accept;
    logic        w_winInFrame;
    logic        w_winTake;
    logic        w_abortNow;
    logic        w_colOutWrap;
    logic [15:0] w_outRowsNext;

    // Input rows always lead output rows, so the gap stays non-negative and at most four rows are buffered.
    assign w_rowGap      = r_inRows - r_outRows;
    assign w_sReady      = (r_state == ACTIVE) && (r_inRows < IN_ROWS) && (w_rowGap <= 16'd3);
    assign w_accept      = s_valid & w_sReady;
    assign w_winInFrame  = ((r_state == ACTIVE) || (r_state == DRAIN)) && (r_outRows < OUT_ROWS);
    assign w_winTake     = ld_window_valid & w_winInFrame;
    assign w_abortNow    = abort & (r_state != IDLE);
    assign w_colOutWrap  = (r_colOut == LAST_COL);
    assign w_outRowsNext = r_outRows + ((w_winTake && w_colOutWrap) ? 16'd1 : 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_colIn     <= '0;
            r_inRows    <= '0;
            r_colOut    <= '0;
            r_outRows   <= '0;
            r_ldRstN    <= 1'b0;
            r_mWindow   <= '0;
            r_mValid    <= 1'b0;
            r_mRow      <= '0;
            r_mCol      <= '0;
            r_mSof      <= 1'b0;
            r_mEol      <= 1'b0;
            r_mEof      <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ldRstN    <= 1'b1;
            r_mValid    <= 1'b0;
            r_frameDone <= 1'b0;
            if (w_abortNow) begin
                // A window arriving together with abort belongs to the discarded frame.
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_ldRstN  <= 1'b0;
                r_colIn   <= '0;
                r_inRows  <= '0;
                r_colOut  <= '0;
                r_outRows <= '0;
            end else begin
                if (ld_window_valid && !w_winInFrame) begin
                    r_err <= 1'b1;
                end
                if (w_winTake) begin
                    r_mWindow <= ld_window;
                    r_mValid  <= 1'b1;
                    r_mRow    <= r_outRows + 16'd1;
                    r_mCol    <= r_colOut + 16'd1;
                    r_mSof    <= (r_outRows == 16'd0) && (r_colOut == 16'd0);
                    r_mEol    <= w_colOutWrap;
                    r_mEof    <= w_colOutWrap && (r_outRows == LAST_OUT_ROW);
                    if (w_colOutWrap) begin
                        r_colOut  <= '0;
                        r_outRows <= r_outRows + 16'd1;
                    end else begin
                        r_colOut <= r_colOut + 16'd1;
                    end
                end
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state  <= FLUSH;
                            r_busy   <= 1'b1;
                            r_ldRstN <= 1'b0;
                            r_err    <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        r_state   <= ACTIVE;
                        r_colIn   <= '0;
                        r_inRows  <= '0;
                        r_colOut  <= '0;
                        r_outRows <= '0;
                    end
                    ACTIVE: begin
                        if (w_accept) begin
                            if (r_colIn == LAST_COL) begin
                                r_colIn  <= '0;
                                r_inRows <= r_inRows + 16'd1;
                                if (r_inRows == IN_LAST_ROW) begin
                                    r_state <= DRAIN;
                                end
                            end else begin
                                r_colIn <= r_colIn + 16'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (w_outRowsNext == OUT_ROWS) begin
                            r_state     <= DONE;
                            r_frameDone <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FRAME_SEQ_STATS_EN
    logic [31:0] r_stallCycles;

    // Counts upstream back-pressure while a frame is being loaded; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
        end else if (r_state == FLUSH) begin
            r_stallCycles <= '0;
        end else if ((r_state == ACTIVE) && s_valid && !w_sReady && (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign stall_cycles = r_stallCycles;
`else
    assign stall_cycles = 32'd0;
`endif

    assign s_ready        = w_sReady;
    assign ld_rstN        = r_ldRstN;
    assign ld_pixel       = s_pixel;
    assign ld_pixel_valid = w_accept;
    assign m_window       = r_mWindow;
    assign m_valid        = r_mValid;
    assign m_row          = r_mRow;
    assign m_col          = r_mCol;
    assign m_sof          = r_mSof;
    assign m_eol          = r_mEol;
    assign m_eof          = r_mEof;
    assign busy           = r_busy;
    assign frame_done     = r_frameDone;
    assign err            = r_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomised bench for frame_sequencer (W=8, H=6) against a pixel/window-count reference model,
// with a simple loader that emits one output row of windows per completed input row from row 3 on.
module tb_frame_sequencer;

    localparam int W = 8;
    localparam int H = 6;

    localparam int P_IDLE   = 0;
    localparam int P_FLUSH  = 1;
    localparam int P_ACTIVE = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_DONE   = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic        ld_rstN;
    logic [7:0]  ld_pixel;
    logic        ld_pixel_valid;
    logic [71:0] ld_window;
    logic        ld_window_valid;
    logic [71:0] m_window;
    logic        m_valid;
    logic [15:0] m_row;
    logic [15:0] m_col;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic [31:0] stall_cycles;

    frame_sequencer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .ld_rstN(ld_rstN), .ld_pixel(ld_pixel), .ld_pixel_valid(ld_pixel_valid),
        .ld_window(ld_window), .ld_window_valid(ld_window_valid),
        .m_window(m_window), .m_valid(m_valid), .m_row(m_row), .m_col(m_col),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .frame_done(frame_done), .err(err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: frame progress is tracked only as pixels accepted and windows emitted.
    int          mPhase = P_IDLE;
    bit          mKnown = 1'b0;
    int          mAcc = 0;
    int          mWin = 0;
    bit          mErr = 1'b0;
    logic [31:0] mStall = '0;
    bit          mLdRstN = 1'b0;
    bit          mMValid = 1'b0;
    logic [71:0] mWindow = '0;
    logic [15:0] mRow = '0;
    logic [15:0] mCol = '0;
    bit          mSof = 1'b0;
    bit          mEol = 1'b0;
    bit          mEof = 1'b0;

    int ldPix = 0;
    int ldPend = 0;
    int windowsSeen = 0;
    int doneSeen = 0;

    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit iRst, input bit iStart, input bit iAbort,
                                 input bit iValid, input bit iForceWin);
        bit          expReady;
        bit          winOk;
        bit          wv;
        logic [71:0] win;
        logic [31:0] expStall;
        @(negedge clk);
        rst       = iRst;
        start     = iStart;
        abort     = iAbort;
        s_valid   = iValid;
        s_pixel   = 8'($urandom);
        ld_window = {8'($urandom), $urandom, $urandom};
        ld_window_valid = iForceWin || (ld_rstN && (ldPend > 0) && ($urandom_range(0, 1) == 1));
        #1;
        expReady = (mPhase == P_ACTIVE) && (mAcc / W < H) && ((mAcc / W - mWin / W) <= 3);
        if (mKnown) begin
            checkOutput("s_ready", 72'(s_ready), 72'(expReady));
            checkOutput("ld_pixel_valid", 72'(ld_pixel_valid), 72'(iValid && expReady));
            checkOutput("ld_pixel", 72'(ld_pixel), 72'(s_pixel));
        end
        wv  = ld_window_valid;
        win = ld_window;

        if (!ld_rstN) begin
            ldPix  = 0;
            ldPend = 0;
        end else begin
            if (wv && ldPend > 0) ldPend--;
            if (ld_pixel_valid) begin
                ldPix++;
                if ((ldPix % W == 0) && (ldPix / W >= 3)) ldPend += W;
            end
        end

        if (iRst) begin
            mKnown = 1'b1;
            mPhase = P_IDLE; mAcc = 0; mWin = 0; mErr = 1'b0; mStall = '0;
            mLdRstN = 1'b0; mMValid = 1'b0; mWindow = '0; mRow = '0; mCol = '0;
            mSof = 1'b0; mEol = 1'b0; mEof = 1'b0;
        end else begin
            mLdRstN = 1'b1;
            mMValid = 1'b0;
            if (mPhase == P_FLUSH) mStall = '0;
            else if (mPhase == P_ACTIVE && iValid && !expReady && mStall != 32'hFFFF_FFFF) mStall++;
            if (iAbort && mPhase != P_IDLE) begin
                mPhase = P_IDLE; mAcc = 0; mWin = 0; mLdRstN = 1'b0;
            end else begin
                winOk = wv && (mPhase == P_ACTIVE || mPhase == P_DRAIN) && (mWin / W < H - 2);
                if (wv && !winOk) mErr = 1'b1;
                if (winOk) begin
                    mMValid = 1'b1;
                    mWindow = win;
                    mRow    = 16'(mWin / W + 1);
                    mCol    = 16'(mWin % W + 1);
                    mSof    = (mWin == 0);
                    mEol    = (mWin % W == W - 1);
                    mEof    = (mWin == (H - 2) * W - 1);
                    mWin++;
                end
                case (mPhase)
                    P_IDLE:   if (iStart) begin mPhase = P_FLUSH; mErr = 1'b0; mLdRstN = 1'b0; end
                    P_FLUSH:  begin mPhase = P_ACTIVE; mAcc = 0; mWin = 0; end
                    P_ACTIVE: if (iValid && expReady) begin
                                  mAcc++;
                                  if (mAcc == H * W) mPhase = P_DRAIN;
                              end
                    P_DRAIN:  if (mWin / W == H - 2) mPhase = P_DONE;
                    default:  mPhase = P_IDLE;
                endcase
            end
        end

        @(posedge clk);
        #1;
`ifdef FRAME_SEQ_STATS_EN
        expStall = mStall;
`else
        expStall = 32'd0;
`endif
        checkOutput("ld_rstN", 72'(ld_rstN), 72'(mLdRstN));
        checkOutput("m_valid", 72'(m_valid), 72'(mMValid));
        checkOutput("m_window", m_window, mWindow);
        checkOutput("m_row", 72'(m_row), 72'(mRow));
        checkOutput("m_col", 72'(m_col), 72'(mCol));
        checkOutput("m_sof", 72'(m_sof), 72'(mSof));
        checkOutput("m_eol", 72'(m_eol), 72'(mEol));
        checkOutput("m_eof", 72'(m_eof), 72'(mEof));
        checkOutput("busy", 72'(busy), 72'(mPhase != P_IDLE));
        checkOutput("frame_done", 72'(frame_done), 72'(mPhase == P_DONE));
        checkOutput("err", 72'(err), 72'(mErr));
        checkOutput("stall_cycles", 72'(stall_cycles), 72'(expStall));
        if (m_valid) windowsSeen++;
        if (frame_done) doneSeen++;
    endtask

    task automatic runFrame(input int validPct, input int abortRow);
        int  cycles;
        bit  aborted;
        bit  doAbort;
        windowsSeen = 0;
        doneSeen    = 0;
        aborted     = 1'b0;
        cycles      = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        while (mPhase != P_IDLE && cycles < 3000) begin
            doAbort = (abortRow >= 0) && (mPhase == P_ACTIVE) &&
                      (mAcc / W == abortRow) && (mAcc % W == 3);
            applyStimulus(1'b0, ($urandom_range(0, 19) == 0), doAbort,
                          ($urandom_range(0, 99) < validPct), 1'b0);
            cycles++;
            if (doAbort) aborted = 1'b1;
        end
        if (cycles >= 3000) checkOutput("frame_timeout", 72'(1), 72'(0));
        if (aborted) begin
            checkOutput("abort_no_done", 72'(doneSeen), 72'(0));
        end else begin
            checkOutput("window_count", 72'(windowsSeen), 72'(32));
            checkOutput("done_count", 72'(doneSeen), 72'(1));
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; s_pixel = '0; s_valid = 1'b0;
        ld_window = '0; ld_window_valid = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        runFrame(100, -1);
        runFrame(70, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runFrame(80, -1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runFrame(100, -1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, ($urandom_range(0, 3) != 0), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runFrame(60, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
